// File: rtl/twofour_capture_if.sv
// CPU-side read port of the input-capture FIFO: pop/clear strobes in, head entry and status out.
interface twofour_capture_if #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             rd_en;
    logic             clr_ovf;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic [LVL_W-1:0] level;
    logic             overflow;

    modport master (
        output rd_en, clr_ovf,
        input  rd_data, empty, full, level, overflow
    );

    modport slave (
        input  rd_en, clr_ovf,
        output rd_data, empty, full, level, overflow
    );
endinterface

// File: rtl/twofour_capture.sv
// Input capture: synchronizes cap_in, qualifies edges per edge_sel and timestamps
// each qualifying edge with the counter value into a first-word-fall-through FIFO.
module twofour_capture #(
    parameter int WIDTH       = 24,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   count,
    input  logic               cap_in,
    input  logic [1:0]         edge_sel,
    twofour_capture_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [ARM_W-1:0]       arm_cnt;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level_q;
    logic                   empty_q;
    logic                   full_q;
    logic                   ovf_q;

    logic                   sync_out;
    logic                   rise;
    logic                   fall;
    logic                   capture;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [LVL_W-1:0]       level_nxt;

    // A full FIFO still accepts a push when the head is popped on the same edge.
    always_comb begin
        sync_out  = sync_q[SYNC_STAGES-1];
        rise      = sync_out & ~hist_q;
        fall      = ~sync_out & hist_q;
        capture   = (arm_cnt == ARM_DONE) & ((edge_sel[0] & rise) | (edge_sel[1] & fall));
        pop       = bus.rd_en & ~empty_q;
        push      = capture & (~full_q | pop);
        drop      = capture & full_q & ~pop;
        level_nxt = level_q;
        if (push && !pop) begin
            level_nxt = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            arm_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], cap_in};
            hist_q  <= sync_out;
            // Hold off detection until the synchronizer has flushed its reset value.
            if (arm_cnt != ARM_DONE) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level_q <= level_nxt;
            empty_q <= (level_nxt == '0);
            full_q  <= (level_nxt == LVL_FULL);
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= count;
        end
    end

    // Stale storage is masked whenever the FIFO is empty.
    assign bus.rd_data  = empty_q ? '0 : mem[rd_ptr];
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.level    = level_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_twofour_capture.sv
// Bench for twofour_capture: event-rule reference model with a timestamp scoreboard,
// directed scenarios followed by randomized pin, read, clear and reset activity.
module tb_twofour_capture;
    localparam int WIDTH       = 24;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic [WIDTH-1:0] count    = '0;
    logic             cap_in   = 1'b0;
    logic [1:0]       edge_sel = 2'b00;

    twofour_capture_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    twofour_capture #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .count(count),
        .cap_in(cap_in),
        .edge_sel(edge_sel),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pin value sampled at edge k is pushed at edge k+SYNC_STAGES
    // with the count of that edge, and only once SYNC_STAGES+2 edges have passed since reset.
    logic [WIDTH-1:0] exp_q[$];
    bit               movf     = 1'b0;
    bit               pend_pop = 1'b0;
    bit               started  = 1'b0;
    int               since    = 0;
    bit               samp[8];
    bit               m_new;
    bit               m_old;
    bit               m_cap;
    bit               m_drop;
    int               m_age;
    logic [WIDTH-1:0] m_head;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            movf     = 1'b0;
            pend_pop = 1'b0;
            since    = 0;
            for (int i = 0; i < 8; i++) samp[i] = 1'b0;
            started  = 1'b1;
        end else begin
            m_age  = since + 1;
            m_new  = samp[SYNC_STAGES-1];
            m_old  = samp[SYNC_STAGES];
            m_cap  = (m_age >= SYNC_STAGES + 2) &&
                     ((edge_sel[0] && m_new && !m_old) || (edge_sel[1] && !m_new && m_old));
            m_drop = 1'b0;
            if (m_cap) begin
                if (exp_q.size() == DEPTH && !pend_pop) m_drop = 1'b1;
                else exp_q.push_back(count);
            end
            if (m_drop) movf = 1'b1;
            else if (bus.clr_ovf) movf = 1'b0;
            pend_pop = 1'b0;
            since    = (m_age > 1000) ? 1000 : m_age;
            for (int i = 7; i > 0; i--) samp[i] = samp[i-1];
            samp[0] = cap_in;
        end
        // Monitor: compare outputs mid-cycle and retire the head when a pop is presented.
        #6;
        if (started) begin
            m_head = (exp_q.size() > 0) ? exp_q[0] : '0;
            check("empty",    32'(bus.empty),    32'(exp_q.size() == 0));
            check("full",     32'(bus.full),     32'(exp_q.size() == DEPTH));
            check("level",    32'(bus.level),    32'(exp_q.size()));
            check("overflow", 32'(bus.overflow), 32'(movf));
            check("rd_data",  32'(bus.rd_data),  32'(m_head));
            if (bus.rd_en === 1'b1 && exp_q.size() > 0) begin
                check("pop_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
                pend_pop = 1'b1;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
            count = count + 1'b1;
        end
    endtask

    logic [WIDTH-1:0] ts;

    initial begin
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        // Pin already high across reset release must not be captured.
        cap_in   = 1'b1;
        edge_sel = 2'b11;
        tick(3);
        rst = 1'b0;
        tick(12);
        check("arm_empty", 32'(bus.empty), 32'd1);
        check("arm_level", 32'(bus.level), 32'd0);

        // Rising edge only, timestamp is the count two edges after first sampling.
        edge_sel = 2'b01;
        cap_in   = 1'b0;
        count    = 24'h000010;
        tick(4);
        cap_in = 1'b1;
        ts     = count + 24'd2;
        tick(3);
        check("rise_ts", 32'(bus.rd_data), 32'(ts));
        tick(2);
        cap_in = 1'b0;
        tick(5);
        check("fall_ignored", 32'(bus.level), 32'd1);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        check("rise_popped", 32'(bus.empty), 32'd1);

        // Both edges across counter wrap.
        edge_sel = 2'b11;
        count    = 24'hFFFFFD;
        cap_in   = 1'b1;
        tick(4);
        cap_in = 1'b0;
        tick(3);
        check("wrap_level", 32'(bus.level), 32'd2);
        check("wrap_first", 32'(bus.rd_data), 32'h00FFFFFF);
        bus.rd_en = 1'b1;
        tick(1);
        check("wrap_second", 32'(bus.rd_data), 32'h00000003);
        tick(1);
        bus.rd_en = 1'b0;
        check("wrap_drained", 32'(bus.empty), 32'd1);

        // Five rising edges with no reads: the fifth is dropped.
        edge_sel = 2'b01;
        for (int i = 0; i < 5; i++) begin
            cap_in = 1'b1;
            tick(2);
            cap_in = 1'b0;
            tick(2);
        end
        tick(3);
        check("ovf_full",  32'(bus.full),     32'd1);
        check("ovf_level", 32'(bus.level),    32'd4);
        check("ovf_set",   32'(bus.overflow), 32'd1);
        bus.clr_ovf = 1'b1;
        tick(1);
        bus.clr_ovf = 1'b0;
        tick(1);
        check("ovf_cleared", 32'(bus.overflow), 32'd0);
        bus.clr_ovf = 1'b1;
        cap_in      = 1'b1;
        tick(3);
        check("ovf_clr_vs_drop", 32'(bus.overflow), 32'd1);
        bus.clr_ovf = 1'b0;
        cap_in      = 1'b0;
        tick(3);

        // Push coinciding with a pop on a full FIFO.
        bus.clr_ovf = 1'b1;
        tick(1);
        bus.clr_ovf = 1'b0;
        cap_in = 1'b1;
        ts     = count + 24'd2;
        tick(2);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        check("pp_level", 32'(bus.level),    32'd4);
        check("pp_ovf",   32'(bus.overflow), 32'd0);
        cap_in    = 1'b0;
        tick(2);
        bus.rd_en = 1'b1;
        tick(3);
        bus.rd_en = 1'b0;
        check("pp_tail", 32'(bus.rd_data), 32'(ts));
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;

        // Disabled: toggles produce nothing.
        edge_sel = 2'b00;
        for (int i = 0; i < 6; i++) begin
            cap_in = ~cap_in;
            tick(2);
        end
        tick(4);
        check("dis_empty", 32'(bus.empty), 32'd1);

        // Two stored entries discarded by a one-cycle reset.
        edge_sel = 2'b01;
        cap_in   = 1'b0;
        tick(3);
        for (int i = 0; i < 2; i++) begin
            cap_in = 1'b1;
            tick(2);
            cap_in = 1'b0;
            tick(2);
        end
        tick(2);
        check("pre_rst_level", 32'(bus.level), 32'd2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_empty", 32'(bus.empty),   32'd1);
        check("rst_data",  32'(bus.rd_data), 32'd0);
        check("rst_level", 32'(bus.level),   32'd0);
        tick(6);

        // Randomized activity, checked entirely by the model and scoreboard.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0) cap_in = ~cap_in;
            if ($urandom_range(19) == 0) edge_sel = 2'($urandom_range(3));
            bus.rd_en   = ($urandom_range(2) == 0);
            bus.clr_ovf = ($urandom_range(9) == 0);
            rst         = ($urandom_range(299) == 0);
            if ($urandom_range(49) == 0) count = WIDTH'($urandom);
            tick(1);
        end
        rst         = 1'b0;
        bus.clr_ovf = 1'b0;
        bus.rd_en   = 1'b1;
        tick(DEPTH + 4);
        bus.rd_en = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
